// File: rtl/clk_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_sched
// Purpose  : Programmable tick-rate controller. Owns the divider counter and
//            emits a one-clk-wide slow_clk tick every (offset+1) cycles.
//            New offsets/counts arrive over a valid/ready handshake and are
//            staged in a shadow register while running, taking effect only on
//            a tick boundary so no runt or stretched periods are produced.
//            Supports continuous (count=0) or N-tick burst operation.
// Ports    : clk, rst_n           - clock, async active-low reset
//            cfg_valid/cfg_ready  - configuration handshake
//            cfg_offset/cfg_count - divide offset / ticks per burst (0=cont.)
//            start, stop          - begin (IDLE only) / abort ticking
//            slow_clk             - tick pulse
//            busy, done           - RUN indicator / burst-complete pulse
//            cur_offset           - offset currently in effect
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_sched #(
    parameter int OFF_W = 31,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [OFF_W-1:0] cfg_offset,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             start,
    input  logic             stop,
    output logic             slow_clk,
    output logic             busy,
    output logic             done,
    output logic [OFF_W-1:0] cur_offset
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [OFF_W-1:0] r_cnt;
    logic [OFF_W-1:0] r_off;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_rem;
    logic [OFF_W-1:0] r_sh_off;
    logic [CNT_W-1:0] r_sh_cnt;
    logic             r_sh_full;
    logic             r_done;

    logic             w_hs;
    logic             w_run;
    logic             w_at_end;
    logic             w_tick;
    logic             w_final;
    logic             w_leave;
    logic             w_apply;
    logic             w_start;

    assign w_run    = (r_state == S_RUN);
    assign w_hs     = cfg_valid && cfg_ready;
    // Counter never exceeds the active offset, so equality is a safe wrap
    // test even at the all-ones maximum offset.
    assign w_at_end = w_run && (r_cnt == r_off);
    // stop suppresses a coincident tick entirely.
    assign w_tick   = w_at_end && !stop;
    assign w_final  = w_tick && (r_count != '0) && (r_rem == CNT_W'(1));
    assign w_leave  = w_run && (stop || w_final);
    // Shadow takes effect on a tick boundary, or on the stop edge into IDLE.
    assign w_apply  = r_sh_full && w_run && (stop || w_tick);
    assign w_start  = (r_state == S_IDLE) && start && !stop;

    assign slow_clk   = w_tick;
    assign busy       = w_run;
    assign done       = r_done;
    assign cfg_ready  = !r_sh_full;
    assign cur_offset = r_off;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_leave) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_off     <= '0;
            r_count   <= '0;
            r_rem     <= '0;
            r_sh_off  <= '0;
            r_sh_cnt  <= '0;
            r_sh_full <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_final;

            if (w_start) begin
                r_cnt <= '0;
            end else if (w_run) begin
                if (stop || w_at_end) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + OFF_W'(1);
                end
            end

            if (w_apply) begin
                r_off     <= r_sh_off;
                r_count   <= r_sh_cnt;
                r_rem     <= r_sh_cnt;
                r_sh_full <= 1'b0;
            end else begin
                if (w_tick && (r_count != '0)) begin
                    r_rem <= r_rem - CNT_W'(1);
                end
                if (w_hs) begin
                    // A transfer landing on the edge back to IDLE would
                    // otherwise strand in the shadow, so load it directly.
                    if (!w_run || w_leave) begin
                        r_off   <= cfg_offset;
                        r_count <= cfg_count;
                    end else begin
                        r_sh_off  <= cfg_offset;
                        r_sh_cnt  <= cfg_count;
                        r_sh_full <= 1'b1;
                    end
                end
            end

            if (w_start) begin
                r_rem <= w_hs ? cfg_count : r_count;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_sched
// Purpose  : Self-checking bench for clk_div_sched: per-cycle vector table for
//            continuous, burst and offset-0 operation, plus directed sequences
//            for live reconfiguration, stop priority, burst-end with pending
//            shadow and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [30:0] cfg_offset = '0;
    logic [15:0] cfg_count = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        slow_clk;
    logic        busy;
    logic        done;
    logic [30:0] cur_offset;

    int n_cmp = 0;
    int n_err = 0;

    clk_div_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_offset (cfg_offset),
        .cfg_count  (cfg_count),
        .start      (start),
        .stop       (stop),
        .slow_clk   (slow_clk),
        .busy       (busy),
        .done       (done),
        .cur_offset (cur_offset)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [30:0] off;
        logic [15:0] cnt;
        logic        st;
        logic        sp;
        logic        eslow;
        logic        ebusy;
        logic        edone;
        logic        erdy;
        logic [30:0] ecur;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic v, input int off, input int cnt,
                       input logic st, input logic sp,
                       input logic eslow, input logic ebusy, input logic edone,
                       input logic erdy, input int ecur);
        vec_t e;
        e.v = v; e.off = off[30:0]; e.cnt = cnt[15:0]; e.st = st; e.sp = sp;
        e.eslow = eslow; e.ebusy = ebusy; e.edone = edone; e.erdy = erdy;
        e.ecur = ecur[30:0];
        vq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic eslow, input logic ebusy,
                           input logic edone, input logic erdy, input int ecur);
        chk({tag, ".slow_clk"},   {31'd0, slow_clk},  {31'd0, eslow});
        chk({tag, ".busy"},       {31'd0, busy},      {31'd0, ebusy});
        chk({tag, ".done"},       {31'd0, done},      {31'd0, edone});
        chk({tag, ".cfg_ready"},  {31'd0, cfg_ready}, {31'd0, erdy});
        chk({tag, ".cur_offset"}, {1'b0, cur_offset}, ecur);
    endtask

    task automatic set_in(input logic v, input int off, input int cnt,
                          input logic st, input logic sp);
        cfg_valid  = v;
        cfg_offset = off[30:0];
        cfg_count  = cnt[15:0];
        start      = st;
        stop       = sp;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- vector table ----------------
        // continuous, offset 4
        add(1, 4, 0, 0, 0,  0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0,  0, 0, 0, 1, 4);
        add(0, 0, 0, 0, 0,  0, 1, 0, 1, 4);
        add(0, 0, 0, 0, 0,  0, 1, 0, 1, 4);
        add(0, 0, 0, 0, 0,  0, 1, 0, 1, 4);
        add(0, 0, 0, 0, 0,  0, 1, 0, 1, 4);
        add(0, 0, 0, 0, 0,  1, 1, 0, 1, 4);
        add(0, 0, 0, 0, 0,  0, 1, 0, 1, 4);
        add(0, 0, 0, 0, 0,  0, 1, 0, 1, 4);
        add(0, 0, 0, 0, 0,  0, 1, 0, 1, 4);
        add(0, 0, 0, 0, 0,  0, 1, 0, 1, 4);
        add(0, 0, 0, 0, 0,  1, 1, 0, 1, 4);
        add(0, 0, 0, 0, 1,  0, 1, 0, 1, 4);
        // burst offset 2, 3 ticks
        add(1, 2, 3, 0, 0,  0, 0, 0, 1, 4);
        add(0, 0, 0, 1, 0,  0, 0, 0, 1, 2);
        add(0, 0, 0, 0, 0,  0, 1, 0, 1, 2);
        add(0, 0, 0, 0, 0,  0, 1, 0, 1, 2);
        add(0, 0, 0, 0, 0,  1, 1, 0, 1, 2);
        add(0, 0, 0, 0, 0,  0, 1, 0, 1, 2);
        add(0, 0, 0, 0, 0,  0, 1, 0, 1, 2);
        add(0, 0, 0, 0, 0,  1, 1, 0, 1, 2);
        add(0, 0, 0, 0, 0,  0, 1, 0, 1, 2);
        add(0, 0, 0, 0, 0,  0, 1, 0, 1, 2);
        add(0, 0, 0, 0, 0,  1, 1, 0, 1, 2);
        add(0, 0, 0, 0, 0,  0, 0, 1, 1, 2);
        add(0, 0, 0, 0, 0,  0, 0, 0, 1, 2);
        // offset 0: tick every cycle, stop suppresses
        add(1, 0, 0, 0, 0,  0, 0, 0, 1, 2);
        add(0, 0, 0, 1, 0,  0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0,  1, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0,  1, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0,  1, 1, 0, 1, 0);
        add(0, 0, 0, 0, 1,  0, 1, 0, 1, 0);
        add(0, 0, 0, 0, 0,  0, 0, 0, 1, 0);

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < vq.size(); i++) begin
            set_in(vq[i].v, int'(vq[i].off), int'(vq[i].cnt), vq[i].st, vq[i].sp);
            #1;
            chk_all($sformatf("row%0d", i), vq[i].eslow, vq[i].ebusy,
                    vq[i].edone, vq[i].erdy, int'(vq[i].ecur));
            cyc();
        end

        // ---------------- live reconfiguration ----------------
        set_in(1, 9, 0, 0, 0); cyc();
        set_in(0, 0, 0, 1, 0); cyc();
        set_in(0, 0, 0, 0, 0);
        repeat (4) cyc();                       // counter = 4
        set_in(1, 1, 0, 0, 0); #1; chk_all("rc_send", 0, 1, 0, 1, 9); cyc();
        set_in(1, 7, 0, 0, 0);                  // second offer must stall
        for (int k = 5; k <= 8; k++) begin
            #1; chk_all($sformatf("rc_wait%0d", k), 0, 1, 0, 0, 9); cyc();
        end
        set_in(0, 0, 0, 0, 0); #1; chk_all("rc_bound", 1, 1, 0, 0, 9); cyc();
        for (int k = 0; k < 4; k++) begin
            #1; chk_all($sformatf("rc_new%0d", k), logic'(k % 2), 1, 0, 1, 1); cyc();
        end
        set_in(0, 0, 0, 0, 1); cyc();
        set_in(0, 0, 0, 0, 0); #1; chk_all("rc_idle", 0, 0, 0, 1, 1); cyc();

        // ---------------- stop priority ----------------
        set_in(1, 3, 0, 0, 0); cyc();
        set_in(0, 0, 0, 1, 0); cyc();
        set_in(0, 0, 0, 0, 0);
        repeat (3) cyc();                       // counter = 3 (tick cycle)
        set_in(0, 0, 0, 0, 1); #1; chk_all("sp_tick", 0, 1, 0, 1, 3); cyc();
        set_in(0, 0, 0, 0, 0); #1; chk_all("sp_idle", 0, 0, 0, 1, 3); cyc();
        set_in(0, 0, 0, 1, 1); cyc();
        set_in(0, 0, 0, 0, 0); #1; chk_all("sp_both", 0, 0, 0, 1, 3); cyc();
        #1; chk_all("sp_both2", 0, 0, 0, 1, 3); cyc();

        // ---------------- burst end with pending shadow ----------------
        set_in(1, 2, 2, 0, 0); cyc();
        set_in(0, 0, 0, 1, 0); cyc();
        set_in(0, 0, 0, 0, 0);
        cyc(); cyc();                           // counter = 2
        #1; chk_all("be_t1", 1, 1, 0, 1, 2); cyc();
        set_in(1, 5, 1, 0, 0); #1; chk_all("be_post", 0, 1, 0, 1, 2); cyc();
        set_in(0, 0, 0, 0, 0); #1; chk_all("be_wait", 0, 1, 0, 0, 2); cyc();
        #1; chk_all("be_t2", 1, 1, 0, 0, 2); cyc();
        #1; chk_all("be_done", 0, 0, 1, 1, 5); cyc();
        #1; chk_all("be_after", 0, 0, 0, 1, 5);
        set_in(0, 0, 0, 1, 0); cyc();
        set_in(0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            #1; chk_all($sformatf("be_r%0d", k), logic'(k == 5), 1, 0, 1, 5); cyc();
        end
        #1; chk_all("be_rdone", 0, 0, 1, 1, 5); cyc();
        #1; chk_all("be_end", 0, 0, 0, 1, 5); cyc();

        // ---------------- asynchronous reset mid-RUN ----------------
        set_in(1, 3, 0, 0, 0); cyc();
        set_in(0, 0, 0, 1, 0); cyc();
        set_in(0, 0, 0, 0, 0);
        cyc(); cyc();                           // counter = 2
        #1; chk_all("rst_pre", 0, 1, 0, 1, 3);
        #1; rst_n = 1'b0;
        #1; chk_all("rst_async", 0, 0, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        #1; chk_all("rst_rel", 0, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
